ysyx_23060072_if_stage: RTL and testbench
=========================================

// Module: ysyx_23060072_if_stage
// PURPOSE
//  Instruction-fetch stage. Holds the PC and issues one instruction-memory request at a time.
//  Passes each returned word through ysyx_23060072_simple_bpu and buffers instr/pc/prediction for ID.
//  Steers the next PC from the prediction, or from an EX redirect on mispredict or jalr.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC of the first fetch after reset
// PORTS
//  clk_i          in   1   clock; all state updates on rising edge
//  rst_n_i        in   1   reset, synchronous, active-low
//  inst_req_o     out  1   fetch request; held until inst_gnt_i
//  inst_addr_o    out  32  fetch address (= pc_q)
//  inst_gnt_i     in   1   memory accepted request this cycle
//  inst_rvalid_i  in   1   read data valid (at least 1 cycle after gnt)
//  inst_rdata_i   in   32  instruction word
//  redirect_i     in   1   EX flush/redirect request
//  redirect_pc_i  in   32  redirect target
//  if_valid_o     out  1   buffered instruction valid to ID
//  id_ready_i     in   1   ID accepts this cycle
//  if_instr_o     out  32  buffered instruction
//  if_pc_o        out  32  PC of buffered instruction
//  if_pred_o      out  1   BPU predict_flag for that instruction
//  if_pred_pc_o   out  32  predicted next PC (pc+4 when if_pred_o=0)
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): state=REQ, pc_q=RESET_PC, drop_q=0, buffer cleared.
//   Outputs next cycle: if_valid_o=0, if_instr/pc/pred/pred_pc=0, inst_req_o=1, inst_addr_o=RESET_PC.
//   Reset mid-transaction abandons the outstanding request. Responses arriving in REQ are ignored.
//  FSM, one outstanding request max:
//   REQ:   inst_req_o=1. On gnt -> WAIT.
//   WAIT:  inst_req_o=0. On rvalid:
//          - drop_q=1: discard, drop_q<=0, -> REQ.
//          - otherwise: latch rdata, pc_q, predict_flag_o; pred_pc = flag ? predict_pc_o : pc_q+4;
//            pc_q<=pred_pc; -> VALID.
//   VALID: if_valid_o=1, buffer outputs stable. On id_ready_i -> REQ, next address = pc_q.
//  BPU input: instr_rdata_i=inst_rdata_i, instr_addr_i=pc_q. Output sampled only in WAIT&rvalid.
//   Purely combinational, so nothing is added to latency.
//  Redirect has priority over every other event in the same cycle:
//   - Always: pc_q <= {redirect_pc_i[31:2],2'b00}.
//   - REQ, no gnt: stay REQ; inst_addr_o shows the new PC next cycle.
//   - REQ with gnt: -> WAIT, drop_q<=1 (granted old-address fetch is squashed).
//   - WAIT, no rvalid: drop_q<=1. WAIT with rvalid: discard word, -> REQ.
//   - VALID: buffer invalidated (if_valid_o=0 next cycle), even if id_ready_i=1; -> REQ.
//  Best-case throughput: gnt same cycle, rvalid next cycle, ID ready -> 1 instr per 3 cycles.
//  pc+4 and target adders wrap modulo 2^32; no overflow flag.
//  if_valid_o never depends combinationally on id_ready_i. Buffer outputs change only on entry to VALID.
// STRUCTURE
//  Shared define file: opcode constants, enable/disable, state encodings (REQ=2'd0, WAIT=2'd1, VALID=2'd2).
//  Sub-module: one instance of ysyx_23060072_simple_bpu. FSM, PC register and buffer are local.
// TESTING
//  1 Reset, memory grants immediately, rvalid +1, addi words, ID always ready
//     -> fetch addrs 8000_0000, 8000_0004, 8000_0008; if_valid_o on 1 cycle in every 3.
//  2 jal x0,+16 (32'h0100006F) at 8000_0000
//     -> if_pred_o=1, if_pred_pc_o=8000_0010; next inst_addr_o=8000_0010.
//  3 Backward beq (32'hFE000EE3, imm=-4) at 8000_0020
//     -> pred=1, pred_pc=8000_001C. Forward bne at same PC -> pred=0, pred_pc=8000_0024.
//  4 Redirect to 8000_0100 while in WAIT, rvalid 3 cycles later with 32'h00000013
//     -> word dropped, no if_valid_o; next req addr 8000_0100.
//  5 VALID held with id_ready_i=0 for 5 cycles -> outputs stable, no new req.
//     Then redirect together with id_ready_i=1 -> if_valid_o=0, req to redirect PC.
//  6 Redirect in the same cycle as gnt; redirect_pc=8000_0203
//     -> response dropped, next addr 8000_0200.
//     Reset asserted in WAIT -> next cycle REQ at RESET_PC, late rvalid ignored.

Source files
------------

// File: rtl/ysyx_23060072_if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Includes the FSM state encoding, opcode values and the IF->ID buffer layout.
package ysyx_23060072_if_stage_pkg;

    localparam logic EN  = 1'b1;
    localparam logic DIS = 1'b0;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] pred_pc;
    } if_id_t;

endpackage

// File: rtl/ysyx_23060072_if_stage_if.sv
// Bus bundle of the IF stage: instruction memory, EX redirect and ID handshake.
// The master side is the IF stage; the slave side is its environment.
interface ysyx_23060072_if_stage_if;

    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_gnt_i;
    logic        inst_rvalid_i;
    logic [31:0] inst_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_pred_o;
    logic [31:0] if_pred_pc_o;

    modport master (
        output inst_req_o, inst_addr_o,
        input  inst_gnt_i, inst_rvalid_i, inst_rdata_i,
        input  redirect_i, redirect_pc_i,
        output if_valid_o,
        input  id_ready_i,
        output if_instr_o, if_pc_o, if_pred_o, if_pred_pc_o
    );

    modport slave (
        input  inst_req_o, inst_addr_o,
        output inst_gnt_i, inst_rvalid_i, inst_rdata_i,
        output redirect_i, redirect_pc_i,
        input  if_valid_o,
        output id_ready_i,
        input  if_instr_o, if_pc_o, if_pred_o, if_pred_pc_o
    );

endinterface

// File: rtl/ysyx_23060072_if_stage_bpu.sv
// Static predictor: jal always taken, conditional branches taken when backward.
// jalr and everything else fall through to pc+4 and are left to EX.
module ysyx_23060072_simple_bpu
    import ysyx_23060072_if_stage_pkg::*;
(
    input  logic [31:0] instr_rdata_i,
    input  logic [31:0] instr_addr_i,
    output logic        predict_flag_o,
    output logic [31:0] predict_pc_o
);

    logic [6:0]  opcode;
    logic [31:0] imm_j;
    logic [31:0] imm_b;

    assign opcode = instr_rdata_i[6:0];

    assign imm_j = {{11{instr_rdata_i[31]}}, instr_rdata_i[31],
                    instr_rdata_i[19:12], instr_rdata_i[20],
                    instr_rdata_i[30:21], 1'b0};

    assign imm_b = {{19{instr_rdata_i[31]}}, instr_rdata_i[31],
                    instr_rdata_i[7], instr_rdata_i[30:25],
                    instr_rdata_i[11:8], 1'b0};

    always_comb begin
        predict_flag_o = DIS;
        predict_pc_o   = instr_addr_i + 32'd4;
        unique case (1'b1)
            (opcode == OP_JAL): begin
                predict_flag_o = EN;
                predict_pc_o   = instr_addr_i + imm_j;
            end
            (opcode == OP_BRANCH): begin
                // backward-taken / forward-not-taken
                predict_flag_o = instr_rdata_i[31];
                predict_pc_o   = instr_rdata_i[31] ?
                                 instr_addr_i + imm_b :
                                 instr_addr_i + 32'd4;
            end
            default: begin
                predict_flag_o = DIS;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060072_if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM,
// static branch prediction and a one-entry buffer towards ID.
module ysyx_23060072_if_stage
    import ysyx_23060072_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    ysyx_23060072_if_stage_if.master bus
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    if_id_t      buf_q, buf_d;

    logic        bpu_flag;
    logic [31:0] bpu_pc;
    logic [31:0] pred_pc;
    logic [31:0] redir_pc;
    logic        unused_redir_lsb;

    ysyx_23060072_simple_bpu u_bpu (
        .instr_rdata_i  (bus.inst_rdata_i),
        .instr_addr_i   (pc_q),
        .predict_flag_o (bpu_flag),
        .predict_pc_o   (bpu_pc)
    );

    assign pred_pc          = bpu_flag ? bpu_pc : pc_q + 32'd4;
    assign redir_pc         = {bus.redirect_pc_i[31:2], 2'b00};
    assign unused_redir_lsb = ^bus.redirect_pc_i[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        buf_d   = buf_q;
        if (bus.redirect_i) begin
            pc_d = redir_pc;
            unique case (state_q)
                S_REQ: begin
                    if (bus.inst_gnt_i) begin
                        state_d = S_WAIT;
                        drop_d  = EN;
                    end
                end
                S_WAIT: begin
                    if (bus.inst_rvalid_i) begin
                        state_d = S_REQ;
                        drop_d  = DIS;
                    end else begin
                        drop_d  = EN;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (bus.inst_gnt_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.inst_rvalid_i) begin
                        if (drop_q) begin
                            drop_d  = DIS;
                            state_d = S_REQ;
                        end else begin
                            buf_d.instr   = bus.inst_rdata_i;
                            buf_d.pc      = pc_q;
                            buf_d.pred    = bpu_flag;
                            buf_d.pred_pc = pred_pc;
                            pc_d          = pred_pc;
                            state_d       = S_VALID;
                        end
                    end
                end
                default: begin
                    if (bus.id_ready_i) state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= DIS;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.inst_req_o   = (state_q == S_REQ);
    assign bus.inst_addr_o  = pc_q;
    assign bus.if_valid_o   = (state_q == S_VALID);
    assign bus.if_instr_o   = buf_q.instr;
    assign bus.if_pc_o      = buf_q.pc;
    assign bus.if_pred_o    = buf_q.pred;
    assign bus.if_pred_pc_o = buf_q.pred_pc;

endmodule

// File: tb/tb_ysyx_23060072_if_stage.sv
// Directed bench for the IF stage: fetch cadence, prediction,
// redirect squashing, ID back-pressure and reset mid-transaction.
module tb_ysyx_23060072_if_stage;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;

    ysyx_23060072_if_stage_if bus ();

    ysyx_23060072_if_stage #(
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // waits for a request, grants it, returns the word one cycle later
    task automatic run_fetch(input logic [31:0] w);
        int n;
        n = 0;
        while (bus.inst_req_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (bus.inst_req_o !== 1'b1)
            $display("FAIL fetch_timeout: req=%b expected 1", bus.inst_req_o);
        else
            pass_cnt++;
        bus.inst_gnt_i = 1'b1;
        @(negedge clk);
        bus.inst_gnt_i    = 1'b0;
        bus.inst_rvalid_i = 1'b1;
        bus.inst_rdata_i  = w;
        @(negedge clk);
        bus.inst_rvalid_i = 1'b0;
    endtask

    task automatic redirect_now(input logic [31:0] tgt);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = tgt;
        @(negedge clk);
        bus.redirect_i    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("rst_addr", bus.inst_addr_o, 32'h8000_0000);
        chk("rst_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("rst_instr", bus.if_instr_o, 32'd0);
        chk("rst_pc", bus.if_pc_o, 32'd0);
        chk("rst_pred", {31'b0, bus.if_pred_o}, 32'd0);
        chk("rst_pred_pc", bus.if_pred_pc_o, 32'd0);
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        a = 32'h8000_0000;
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_req", {31'b0, bus.inst_req_o}, 32'd1);
            chk("seq_addr", bus.inst_addr_o, a);
            chk("seq_valid_a", {31'b0, bus.if_valid_o}, 32'd0);
            bus.inst_gnt_i = 1'b1;
            @(negedge clk);
            bus.inst_gnt_i = 1'b0;
            chk("seq_wait_req", {31'b0, bus.inst_req_o}, 32'd0);
            chk("seq_valid_b", {31'b0, bus.if_valid_o}, 32'd0);
            bus.inst_rvalid_i = 1'b1;
            bus.inst_rdata_i  = 32'h0000_0013 | (i << 7);
            @(negedge clk);
            bus.inst_rvalid_i = 1'b0;
            chk("seq_valid_c", {31'b0, bus.if_valid_o}, 32'd1);
            chk("seq_req_c", {31'b0, bus.inst_req_o}, 32'd0);
            chk("seq_pc", bus.if_pc_o, a);
            chk("seq_instr", bus.if_instr_o, 32'h0000_0013 | (i << 7));
            chk("seq_pred", {31'b0, bus.if_pred_o}, 32'd0);
            chk("seq_pred_pc", bus.if_pred_pc_o, a + 32'd4);
            @(negedge clk);
            a = a + 32'd4;
        end
    endtask

    task automatic test_jal();
        do_reset();
        bus.id_ready_i = 1'b1;
        run_fetch(32'h0100_006F);
        chk("jal_valid", {31'b0, bus.if_valid_o}, 32'd1);
        chk("jal_pc", bus.if_pc_o, 32'h8000_0000);
        chk("jal_pred", {31'b0, bus.if_pred_o}, 32'd1);
        chk("jal_pred_pc", bus.if_pred_pc_o, 32'h8000_0010);
        @(negedge clk);
        chk("jal_next_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("jal_next_addr", bus.inst_addr_o, 32'h8000_0010);
    endtask

    task automatic test_branch();
        redirect_now(32'h8000_0020);
        chk("br_redir_addr", bus.inst_addr_o, 32'h8000_0020);
        run_fetch(32'hFE00_0EE3);
        chk("beq_pred", {31'b0, bus.if_pred_o}, 32'd1);
        chk("beq_pred_pc", bus.if_pred_pc_o, 32'h8000_001C);
        chk("beq_pc", bus.if_pc_o, 32'h8000_0020);
        @(negedge clk);
        chk("beq_next_addr", bus.inst_addr_o, 32'h8000_001C);
        redirect_now(32'h8000_0020);
        run_fetch(32'h0000_1463);
        chk("bne_pred", {31'b0, bus.if_pred_o}, 32'd0);
        chk("bne_pred_pc", bus.if_pred_pc_o, 32'h8000_0024);
        @(negedge clk);
        chk("bne_next_addr", bus.inst_addr_o, 32'h8000_0024);
    endtask

    task automatic test_redirect_wait();
        bus.inst_gnt_i = 1'b1;
        @(negedge clk);
        bus.inst_gnt_i = 1'b0;
        chk("rw_in_wait", {31'b0, bus.inst_req_o}, 32'd0);
        redirect_now(32'h8000_0100);
        @(negedge clk);
        chk("rw_hold_req", {31'b0, bus.inst_req_o}, 32'd0);
        @(negedge clk);
        bus.inst_rvalid_i = 1'b1;
        bus.inst_rdata_i  = 32'h0000_0013;
        @(negedge clk);
        bus.inst_rvalid_i = 1'b0;
        chk("rw_dropped", {31'b0, bus.if_valid_o}, 32'd0);
        chk("rw_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("rw_addr", bus.inst_addr_o, 32'h8000_0100);
    endtask

    task automatic test_backpressure();
        bus.id_ready_i = 1'b0;
        run_fetch(32'h0050_0093);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, bus.if_valid_o}, 32'd1);
            chk("bp_req", {31'b0, bus.inst_req_o}, 32'd0);
            chk("bp_instr", bus.if_instr_o, 32'h0050_0093);
            chk("bp_pc", bus.if_pc_o, 32'h8000_0100);
            @(negedge clk);
        end
        bus.id_ready_i = 1'b1;
        redirect_now(32'h8000_0040);
        chk("bp_redir_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("bp_redir_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("bp_redir_addr", bus.inst_addr_o, 32'h8000_0040);
    endtask

    task automatic test_redirect_gnt_and_reset();
        bus.inst_gnt_i    = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h8000_0203;
        @(negedge clk);
        bus.inst_gnt_i    = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.inst_rvalid_i = 1'b1;
        bus.inst_rdata_i  = 32'h0000_0013;
        @(negedge clk);
        bus.inst_rvalid_i = 1'b0;
        chk("rg_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("rg_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("rg_addr", bus.inst_addr_o, 32'h8000_0200);
        bus.inst_gnt_i = 1'b1;
        @(negedge clk);
        bus.inst_gnt_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rr_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("rr_addr", bus.inst_addr_o, 32'h8000_0000);
        chk("rr_instr", bus.if_instr_o, 32'd0);
        bus.inst_rvalid_i = 1'b1;
        bus.inst_rdata_i  = 32'h0000_0013;
        @(negedge clk);
        bus.inst_rvalid_i = 1'b0;
        chk("rr_late_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("rr_late_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("rr_late_addr", bus.inst_addr_o, 32'h8000_0000);
    endtask

    initial begin
        total_cnt         = 0;
        pass_cnt          = 0;
        rst_n             = 1'b0;
        bus.inst_gnt_i    = 1'b0;
        bus.inst_rvalid_i = 1'b0;
        bus.inst_rdata_i  = 32'd0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        bus.id_ready_i    = 1'b1;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_jal();
        test_branch();
        test_redirect_wait();
        test_backpressure();
        test_redirect_gnt_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
